// File: rtl/cfg_csr_target_if.sv
// Cfg-bus request/response bundle between the OCL slave decoder (master)
// and a register target (slave). Requests are single-cycle wr/rd pulses;
// the target answers with a one-cycle ack and read data.
interface cfg_csr_target_if;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_wr;
  logic        cfg_rd;
  logic        cfg_ack;
  logic [31:0] cfg_rdata;

  modport master (
    output cfg_addr,
    output cfg_wdata,
    output cfg_wr,
    output cfg_rd,
    input  cfg_ack,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_addr,
    input  cfg_wdata,
    input  cfg_wr,
    input  cfg_rd,
    output cfg_ack,
    output cfg_rdata
  );
endinterface

// File: rtl/cfg_csr_target.sv
// cfg_csr_target: 256 B cfg-bus register slot with ID, CTRL, W1C STATUS,
// IRQ_EN, a 64-bit free-running counter with tear-free CNT_LO/CNT_HI
// readout, and an optional host-to-fabric doorbell FIFO.
// Build option: define CFG_CSR_DB_FIFO_EN to implement the doorbell FIFO
// (offsets 0x18/0x1C); without it those offsets behave as unmapped and
// db_valid/db_data are tied low.
// CNT_INIT is the counter value loaded by reset (0 in normal use).
module cfg_csr_target #(
  parameter logic [31:0] ID_VALUE = 32'hC5A0_0001,
  parameter int unsigned ACK_LAT  = 1,
  parameter int unsigned DB_DEPTH = 8,
  parameter logic [63:0] CNT_INIT = 64'h0
) (
  input  logic            clk,
  input  logic            sync_rst_n,
  cfg_csr_target_if.slave cfg,
  input  logic [7:0]      evt_in,
  output logic [15:0]     ctrl_out,
  output logic            irq_out,
  output logic            db_valid,
  output logic [31:0]     db_data,
  input  logic            db_ready
);

  localparam logic [5:0] OFF_ID      = 6'h00;
  localparam logic [5:0] OFF_CTRL    = 6'h01;
  localparam logic [5:0] OFF_STATUS  = 6'h02;
  localparam logic [5:0] OFF_IRQ_EN  = 6'h03;
  localparam logic [5:0] OFF_CNT_LO  = 6'h04;
  localparam logic [5:0] OFF_CNT_HI  = 6'h05;
  localparam logic [5:0] OFF_DB_PUSH = 6'h06;
  localparam logic [5:0] OFF_DB_STAT = 6'h07;

  localparam logic [2:0] ACK_LAT_M1  = 3'(ACK_LAT - 32'd1);
  localparam logic       ACK_DIRECT  = (ACK_LAT == 32'd1);

  // request decode
  logic        req_s;
  logic        wr_s;
  logic        rd_s;
  logic [5:0]  off_s;
  logic [31:0] rdata_mux_s;

  // ack pipeline
  logic        busy_r;
  logic [2:0]  ack_cnt_r;
  logic        ack_r;
  logic        pend_rd_r;
  logic [31:0] rd_hold_r;
  logic [31:0] rdata_r;

  // register file
  logic [15:0] ctrl_r;
  logic [7:0]  status_r;
  logic [7:0]  status_nxt_s;
  logic [7:0]  w1c_s;
  logic [7:0]  irq_en_r;
  logic [63:0] cnt_r;
  logic [31:0] shadow_r;
  logic        irq_r;
  logic        cnt_clr_s;

  // doorbell view used by the read mux
  logic        ovf_s;
  logic [7:0]  occ_s;

  // Word select plus accept qualification; a pulse while busy is dropped.
  always_comb begin
    off_s = cfg.cfg_addr[7:2];
    req_s = (cfg.cfg_wr | cfg.cfg_rd) & ~busy_r;
    wr_s  = req_s & cfg.cfg_wr;
    rd_s  = req_s & cfg.cfg_rd & ~cfg.cfg_wr;
  end

  // Read data from register values current in the request cycle.
  always_comb begin
    rdata_mux_s = 32'hDEAD_BEEF;
    case (off_s)
      OFF_ID:      rdata_mux_s = ID_VALUE;
      OFF_CTRL:    rdata_mux_s = {16'h0000, ctrl_r};
      OFF_STATUS:  rdata_mux_s = {24'h00_0000, status_r};
      OFF_IRQ_EN:  rdata_mux_s = {24'h00_0000, irq_en_r};
      OFF_CNT_LO:  rdata_mux_s = cnt_r[31:0];
      OFF_CNT_HI:  rdata_mux_s = shadow_r;
`ifdef CFG_CSR_DB_FIFO_EN
      OFF_DB_PUSH: rdata_mux_s = 32'h0000_0000;
      OFF_DB_STAT: rdata_mux_s = {23'h00_0000, ovf_s, occ_s};
`endif
      default:     rdata_mux_s = 32'hDEAD_BEEF;
    endcase
  end

  // Ack timing: direct ack for latency 1, otherwise count down while busy.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      busy_r    <= 1'b0;
      ack_cnt_r <= 3'd0;
      ack_r     <= 1'b0;
      pend_rd_r <= 1'b0;
      rd_hold_r <= 32'h0000_0000;
      rdata_r   <= 32'h0000_0000;
    end else if (req_s) begin
      busy_r    <= ~ACK_DIRECT;
      ack_cnt_r <= ACK_LAT_M1;
      ack_r     <= ACK_DIRECT;
      pend_rd_r <= rd_s;
      rd_hold_r <= rdata_mux_s;
      if (ACK_DIRECT && rd_s) begin
        rdata_r <= rdata_mux_s;
      end
    end else if (busy_r) begin
      ack_cnt_r <= ack_cnt_r - 3'd1;
      if (ack_cnt_r == 3'd1) begin
        ack_r  <= 1'b1;
        busy_r <= 1'b0;
        if (pend_rd_r) begin
          rdata_r <= rd_hold_r;
        end
      end else begin
        ack_r <= 1'b0;
      end
    end else begin
      ack_r <= 1'b0;
    end
  end

  // STATUS next value: W1C clear first, then event set so set wins.
  always_comb begin
    w1c_s        = 8'h00;
    cnt_clr_s    = 1'b0;
    if (wr_s && (off_s == OFF_STATUS)) begin
      w1c_s = cfg.cfg_wdata[7:0];
    end else begin
      w1c_s = 8'h00;
    end
    if (wr_s && (off_s == OFF_CTRL)) begin
      cnt_clr_s = cfg.cfg_wdata[31];
    end else begin
      cnt_clr_s = 1'b0;
    end
    status_nxt_s = (status_r & ~w1c_s) | evt_in;
  end

  // Control/status/enable registers, counter, shadow and registered irq.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      ctrl_r   <= 16'h0000;
      status_r <= 8'h00;
      irq_en_r <= 8'h00;
      cnt_r    <= CNT_INIT;
      shadow_r <= 32'h0000_0000;
      irq_r    <= 1'b0;
    end else begin
      if (wr_s && (off_s == OFF_CTRL)) begin
        ctrl_r <= cfg.cfg_wdata[15:0];
      end
      if (wr_s && (off_s == OFF_IRQ_EN)) begin
        irq_en_r <= cfg.cfg_wdata[7:0];
      end
      // CNT_LO read freezes the high word so CNT_HI pairs with it.
      if (rd_s && (off_s == OFF_CNT_LO)) begin
        shadow_r <= cnt_r[63:32];
      end
      status_r <= status_nxt_s;
      cnt_r    <= cnt_clr_s ? 64'h0 : (cnt_r + 64'd1);
      irq_r    <= |(status_r & irq_en_r);
    end
  end

`ifdef CFG_CSR_DB_FIFO_EN
  localparam int unsigned DB_AW = $clog2(DB_DEPTH);
  localparam logic [DB_AW:0] DB_FULL_CNT = (DB_AW + 1)'(DB_DEPTH);

  logic [31:0]    db_mem_r [DB_DEPTH];
  logic [DB_AW:0] wptr_r;
  logic [DB_AW:0] rptr_r;
  logic [DB_AW:0] db_cnt_s;
  logic           db_ne_s;
  logic           db_full_s;
  logic           db_pop_s;
  logic           db_push_req_s;
  logic           db_push_s;
  logic           db_ovf_set_s;
  logic           db_ovf_clr_s;
  logic           ovf_r;
  logic           unused_s;

  // Occupancy from the wrap-bit pointers; full push is allowed with a pop.
  always_comb begin
    db_cnt_s      = wptr_r - rptr_r;
    db_ne_s       = (wptr_r != rptr_r);
    db_full_s     = (db_cnt_s == DB_FULL_CNT);
    db_pop_s      = db_ne_s & db_ready;
    db_push_req_s = wr_s & (off_s == OFF_DB_PUSH);
    db_push_s     = db_push_req_s & (~db_full_s | db_pop_s);
    db_ovf_set_s  = db_push_req_s & db_full_s & ~db_pop_s;
    db_ovf_clr_s  = wr_s & (off_s == OFF_DB_STAT) & cfg.cfg_wdata[8];
    occ_s         = 8'(db_cnt_s);
    ovf_s         = ovf_r;
  end

  // Pointer and sticky overflow state; reset empties the FIFO.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      wptr_r <= '0;
      rptr_r <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (db_push_s) begin
        wptr_r <= wptr_r + 1'b1;
      end
      if (db_pop_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
      if (db_ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (db_ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Doorbell storage; contents are only visible while db_valid is high.
  always_ff @(posedge clk) begin
    if (db_push_s) begin
      db_mem_r[wptr_r[DB_AW-1:0]] <= cfg.cfg_wdata;
    end
  end

  assign db_valid = db_ne_s;
  assign db_data  = db_ne_s ? db_mem_r[rptr_r[DB_AW-1:0]] : 32'h0000_0000;
  assign unused_s = ^{cfg.cfg_addr[31:8], cfg.cfg_addr[1:0]};
`else
  logic unused_s;

  assign ovf_s    = 1'b0;
  assign occ_s    = 8'h00;
  assign db_valid = 1'b0;
  assign db_data  = 32'h0000_0000;
  assign unused_s = ^{cfg.cfg_addr[31:8], cfg.cfg_addr[1:0],
                      cfg.cfg_wdata[30:16], db_ready, DB_DEPTH[0], ovf_s, occ_s};
`endif

  assign cfg.cfg_ack   = ack_r;
  assign cfg.cfg_rdata = rdata_r;
  assign ctrl_out      = ctrl_r;
  assign irq_out       = irq_r;

endmodule

// File: tb/tb_cfg_csr_target.sv
// Randomized + directed bench for cfg_csr_target. Expected read data and
// ack cycles are queued at issue time; a monitor pops them on cfg_ack.
// Sideband outputs are compared each cycle against a register-map model.
module tb_cfg_csr_target;

  localparam logic [31:0] ID       = 32'hC5A0_0001;
  localparam int          ACK_LAT  = 1;
  localparam int          DB_DEPTH = 8;
  localparam logic [63:0] CNT_INIT = 64'h0000_0001_FFFF_FF80;
`ifdef CFG_CSR_DB_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sync_rst_n;
  logic [7:0]  evt_in;
  logic [15:0] ctrl_out;
  logic        irq_out;
  logic        db_valid;
  logic [31:0] db_data;
  logic        db_ready;

  cfg_csr_target_if cfg_bus();

  cfg_csr_target #(
    .ID_VALUE (ID),
    .ACK_LAT  (ACK_LAT),
    .DB_DEPTH (DB_DEPTH),
    .CNT_INIT (CNT_INIT)
  ) dut (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .cfg        (cfg_bus.slave),
    .evt_in     (evt_in),
    .ctrl_out   (ctrl_out),
    .irq_out    (irq_out),
    .db_valid   (db_valid),
    .db_data    (db_data),
    .db_ready   (db_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  // model state
  logic [15:0] m_ctrl;
  logic [7:0]  m_status;
  logic [7:0]  m_en;
  logic [63:0] m_cnt;
  logic [31:0] m_shadow;
  logic        m_irq;
  logic        m_ovf;
  logic [31:0] m_fifo[$];
  logic [31:0] last_rd;

  // stimulus for the next cycle
  bit          s_wr, s_rd, s_rdy;
  logic [31:0] s_addr, s_wd;
  logic [7:0]  s_evt;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_ctrl = 16'h0; m_status = 8'h0; m_en = 8'h0; m_cnt = CNT_INIT;
    m_shadow = 32'h0; m_irq = 1'b0; m_ovf = 1'b0; last_rd = 32'h0;
    m_fifo.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] off);
    case (off)
      6'd0:    return ID;
      6'd1:    return {16'h0, m_ctrl};
      6'd2:    return {24'h0, m_status};
      6'd3:    return {24'h0, m_en};
      6'd4:    return m_cnt[31:0];
      6'd5:    return m_shadow;
      6'd6:    return FIFO_EN ? 32'h0 : 32'hDEAD_BEEF;
      6'd7:    return FIFO_EN ? {23'h0, m_ovf, 8'(m_fifo.size())} : 32'hDEAD_BEEF;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // One clock cycle: drive, check sideband, queue expectation, advance model.
  task automatic tick();
    logic [5:0]  off;
    logic [7:0]  w1c;
    logic [31:0] exp_data;
    bit          is_wr, is_rd, clr, nirq;
    cfg_bus.cfg_wr    = s_wr;
    cfg_bus.cfg_rd    = s_rd;
    cfg_bus.cfg_addr  = s_addr;
    cfg_bus.cfg_wdata = s_wd;
    evt_in            = s_evt;
    db_ready          = s_rdy;
    chk("ctrl_out", 64'(ctrl_out), 64'(m_ctrl));
    chk("irq_out", 64'(irq_out), 64'(m_irq));
    chk("db_valid", 64'(db_valid), 64'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) exp_data = m_fifo[0];
    else exp_data = 32'h0;
    chk("db_data", 64'(db_data), 64'(exp_data));
    off   = s_addr[7:2];
    is_wr = s_wr;
    is_rd = s_rd && !s_wr;
    if (is_wr || is_rd) begin
      if (is_rd) last_rd = model_read(off);
      sb_q.push_back('{data: last_rd, due: cyc + ACK_LAT});
    end
    nirq = |(m_status & m_en);
    clr  = is_wr && off == 6'd1 && s_wd[31];
    if (is_rd && off == 6'd4) m_shadow = m_cnt[63:32];
    m_cnt = clr ? 64'd0 : m_cnt + 64'd1;
    w1c = (is_wr && off == 6'd2) ? s_wd[7:0] : 8'h00;
    m_status = (m_status & ~w1c) | s_evt;
    if (is_wr && off == 6'd1) m_ctrl = s_wd[15:0];
    if (is_wr && off == 6'd3) m_en = s_wd[7:0];
    if (m_fifo.size() != 0 && s_rdy) void'(m_fifo.pop_front());
    if (FIFO_EN && is_wr && off == 6'd6) begin
      if (m_fifo.size() < DB_DEPTH) m_fifo.push_back(s_wd);
      else m_ovf = 1'b1;
    end
    if (FIFO_EN && is_wr && off == 6'd7 && s_wd[8]) m_ovf = 1'b0;
    m_irq = nirq;
    s_wr = 1'b0; s_rd = 1'b0; s_evt = 8'h00;
    @(negedge clk);
  endtask

  task automatic req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    s_wr = wr; s_rd = rd; s_addr = a; s_wd = d;
    tick();
    repeat (ACK_LAT) tick();
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    if (sync_rst_n === 1'b1) begin
      while (sb_q.size() != 0 && sb_q[0].due < cyc) begin
        vectors++; miscompares++;
        $display("FAIL ack_missing: got no ack expected ack at cycle %0d (now %0d)", sb_q[0].due, cyc);
        void'(sb_q.pop_front());
      end
      if (cfg_bus.cfg_ack === 1'b1) begin
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ack_unexpected: got ack expected none (cycle %0d)", cyc);
        end else begin
          chk("ack_cycle", 64'(cyc), 64'(sb_q[0].due));
          chk("rdata", 64'(cfg_bus.cfg_rdata), 64'(sb_q[0].data));
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int unsigned k, r;
    sync_rst_n = 1'b0;
    s_wr = 1'b0; s_rd = 1'b0; s_rdy = 1'b0; s_addr = 32'h0; s_wd = 32'h0; s_evt = 8'h0;
    cfg_bus.cfg_wr = 1'b0; cfg_bus.cfg_rd = 1'b0;
    cfg_bus.cfg_addr = 32'h0; cfg_bus.cfg_wdata = 32'h0;
    evt_in = 8'h0; db_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(cfg_bus.cfg_ack), 64'd0);
    chk("rst_rdata", 64'(cfg_bus.cfg_rdata), 64'd0);
    chk("rst_ctrl", 64'(ctrl_out), 64'd0);
    chk("rst_irq", 64'(irq_out), 64'd0);
    chk("rst_dbv", 64'(db_valid), 64'd0);
    chk("rst_dbd", 64'(db_data), 64'd0);
    sync_rst_n = 1'b1;

    // reset-state reads
    req(1'b0, 1'b1, 32'h00, 32'h0);
    req(1'b0, 1'b1, 32'h04, 32'h0);
    req(1'b0, 1'b1, 32'h1C, 32'h0);

    // tear-free counter across the low-word wrap
    req(1'b0, 1'b1, 32'h10, 32'h0);
    repeat (150) tick();
    req(1'b0, 1'b1, 32'h14, 32'h0);
    req(1'b0, 1'b1, 32'h10, 32'h0);
    req(1'b0, 1'b1, 32'h14, 32'h0);

    // CTRL with counter clear
    req(1'b1, 1'b0, 32'h04, 32'h8000_1234);
    req(1'b0, 1'b1, 32'h04, 32'h0);
    req(1'b0, 1'b1, 32'h10, 32'h0);
    req(1'b0, 1'b1, 32'h14, 32'h0);

    // STATUS / IRQ, set wins over W1C
    s_evt = 8'h05; tick();
    req(1'b1, 1'b0, 32'h0C, 32'h0000_0004);
    tick(); tick();
    s_evt = 8'h04;
    req(1'b1, 1'b0, 32'h08, 32'h0000_0004);
    req(1'b0, 1'b1, 32'h08, 32'h0);
    req(1'b1, 1'b0, 32'h08, 32'h0000_0004);
    tick(); tick();
    req(1'b0, 1'b1, 32'h08, 32'h0);

    // doorbell overflow and drain
    s_rdy = 1'b0;
    for (int i = 1; i <= DB_DEPTH + 1; i++) req(1'b1, 1'b0, 32'h18, 32'(i));
    req(1'b0, 1'b1, 32'h1C, 32'h0);
    req(1'b0, 1'b1, 32'h18, 32'h0);
    s_rdy = 1'b1;
    repeat (DB_DEPTH + 2) tick();
    s_rdy = 1'b0;
    req(1'b0, 1'b1, 32'h1C, 32'h0);
    req(1'b1, 1'b0, 32'h1C, 32'h0000_0100);
    req(1'b0, 1'b1, 32'h1C, 32'h0);
    // full FIFO: push with a simultaneous pop must not overflow
    for (int i = 0; i < DB_DEPTH; i++) req(1'b1, 1'b0, 32'h18, 32'hA000_0000 + 32'(i));
    s_rdy = 1'b1;
    req(1'b1, 1'b0, 32'h18, 32'h0000_0077);
    s_rdy = 1'b0;
    req(1'b0, 1'b1, 32'h1C, 32'h0);
    s_rdy = 1'b1;
    repeat (DB_DEPTH + 2) tick();

    // unmapped, wr+rd together, upper address bits ignored
    req(1'b0, 1'b1, 32'h40, 32'h0);
    req(1'b1, 1'b1, 32'h04, 32'h0000_5678);
    req(1'b0, 1'b1, 32'hFFFF_FF04, 32'h0);
    req(1'b1, 1'b0, 32'h3C, 32'h1111_1111);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      s_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) s_evt = 8'($urandom);
      if (k < 3) begin
        tick();
      end else begin
        a = $urandom;
        a[7:2] = 6'($urandom_range(0, 17));
        r = $urandom_range(0, 9);
        req(r < 5 || r == 9, r >= 5, a, $urandom);
      end
    end

    // reset while a request is in flight: no ack afterwards, FIFO emptied
    s_rdy = 1'b0;
    req(1'b1, 1'b0, 32'h18, 32'hCAFE_0001);
    cfg_bus.cfg_rd = 1'b1; cfg_bus.cfg_addr = 32'h00;
    @(posedge clk); #1;
    sync_rst_n = 1'b0;
    sb_q.delete();
    cfg_bus.cfg_rd = 1'b0;
    @(negedge clk);
    chk("midrst_ack", 64'(cfg_bus.cfg_ack), 64'd0);
    chk("midrst_dbv", 64'(db_valid), 64'd0);
    chk("midrst_rdata", 64'(cfg_bus.cfg_rdata), 64'd0);
    repeat (2) @(negedge clk);
    sync_rst_n = 1'b1;
    model_reset();
    repeat (6) tick();
    req(1'b0, 1'b1, 32'h00, 32'h0);

    repeat (ACK_LAT + 3) tick();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cfg_csr_target.md
# cfg_csr_target

Cfg-bus register target that sits directly downstream of the OCL slave decoder and occupies one 256 B slot. It consumes single-cycle `wr`/`rd` request pulses and returns an `ack` pulse plus `rdata`. Behind the bus it holds an ID register, control and interrupt registers, a 64-bit cycle counter with tear-free readout, and a host-to-fabric doorbell FIFO.

## Interface
- `ID_VALUE`, default 32'hC5A0_0001: constant returned at offset 0x00.
- `ACK_LAT`, default 1: cycles from the request pulse to `cfg_ack`. Legal range 1..4.
- `DB_DEPTH`, default 8: doorbell FIFO depth. Must be a power of 2, minimum 2.

Ports:
- `clk` in 1: the only clock.
- `sync_rst_n` in 1: asynchronous, active-low reset.
- `cfg_addr` in 32: request address. Bits [7:2] select the word; other bits are ignored.
- `cfg_wdata` in 32: write data.
- `cfg_wr` in 1: one-cycle write request pulse.
- `cfg_rd` in 1: one-cycle read request pulse.
- `cfg_ack` out 1: one-cycle completion pulse.
- `cfg_rdata` out 32: read data, valid in the `cfg_ack` cycle.
- `evt_in` in 8: event pulses that set STATUS bits.
- `ctrl_out` out 16: the CTRL register value.
- `irq_out` out 1: level interrupt.
- `db_valid` out 1: doorbell FIFO head is valid.
- `db_data` out 32: doorbell FIFO head data.
- `db_ready` in 1: fabric pop.

## Operation
Register map (byte offsets):
- 0x00 ID, RO: returns `ID_VALUE`.
- 0x04 CTRL: bits [15:0] are RW and drive `ctrl_out`. Writing 1 to bit 31 clears the counter (self-clearing). Bits [30:16] read 0.
- 0x08 STATUS, W1C, bits [7:0]: bit i is set by `evt_in[i]`. If a set and a clear hit the same bit in the same cycle, set wins.
- 0x0C IRQ_EN, RW, bits [7:0].
- 0x10 CNT_LO, RO: returns counter[31:0]. The same read captures counter[63:32] into a shadow register.
- 0x14 CNT_HI, RO: returns the shadow register, not the live counter.
- 0x18 DB_PUSH, WO: pushes `cfg_wdata`. If the FIFO is full, the data is dropped and OVF is set. Reads return 0.
- 0x1C DB_STAT, RO except bit 8: [7:0] = FIFO occupancy. [8] = OVF sticky, cleared by writing 1 to bit 8.
- Any other offset: reads return 32'hDEAD_BEEF, writes are ignored, and the request is still acked.

Request handling and outputs:
- The upstream holds `cfg_addr`/`cfg_wdata` and issues no new request until `cfg_ack`.
- If `cfg_wr` and `cfg_rd` are asserted together, the request is treated as a write. `cfg_rdata` keeps its previous value.
- Counter: 64-bit, increments every cycle and wraps to 0 after all-ones. In the cycle a clear is written, the counter becomes 0 instead of incrementing.
- `irq_out` is registered: |(STATUS & IRQ_EN), one cycle behind the registers.
- Doorbell FIFO: first-word fall-through. `db_data` is the head whenever `db_valid` = 1. A pop occurs on `db_valid & db_ready`.
  - When the FIFO is full, a push and a pop in the same cycle both succeed; no overflow.
  - When the FIFO is empty, a push is visible on `db_valid` the next cycle.

## Timing
- Reset values: `cfg_ack` 0, `cfg_rdata` 0, `ctrl_out` 0, `irq_out` 0, `db_valid` 0, `db_data` 0. All registers, the counter, the shadow register, OVF and the FIFO pointers reset to 0.
- Request sampled at edge T:
  - Writes update state at T. The effect is visible from T+1.
  - Read data is captured at T, from values current in the request cycle.
  - `cfg_ack` = 1 for exactly one cycle, `ACK_LAT` cycles after the request cycle. With `ACK_LAT`=1 this is the cycle following the pulse.
  - `cfg_rdata` is updated in the ack cycle and holds until the next read ack.
- Implementation: one request-in-flight flag plus an ack delay counter or shift register. A request arriving while one is in flight is a protocol violation and is ignored.
- Reset asserted mid-transaction: the pending ack is discarded and the FIFO is emptied. No ack is issued after reset releases.

## Configuration
- `CFG_CSR_DB_FIFO_EN` defined: the doorbell FIFO, OVF, and offsets 0x18/0x1C are implemented as described above.
- `CFG_CSR_DB_FIFO_EN` not defined: no FIFO storage is built.
  - `db_valid` and `db_data` are tied to 0.
  - Offsets 0x18/0x1C behave as unmapped: reads return 32'hDEAD_BEEF, writes are ignored.
  - All other behaviour is identical.

## Test plan
- After reset, read 0x00, 0x04, 0x1C → 32'hC5A0_0001, 0, 0. Each ack arrives exactly `ACK_LAT` cycles after its `cfg_rd`.
- Write 0x04 = 32'h8000_1234 → `ctrl_out`=16'h1234, counter reads near 0, a read of 0x04 returns 32'h0000_1234.
- Pulse `evt_in`=8'h05 and write IRQ_EN=8'h04 → `irq_out`=1. Write STATUS=8'h04 in the same cycle as a new `evt_in[2]` pulse → bit 2 stays set. A later W1C clears it and `irq_out` drops one cycle after.
- Let the counter cross 32'hFFFF_FFFF in its low word, then read CNT_LO, then CNT_HI → the pair is coherent. CNT_HI equals the high word at the CNT_LO read, not the live value.
- Hold `db_ready`=0 and push `DB_DEPTH`+1 words 1..9 → DB_STAT = 32'h0000_0108. Then set `db_ready`=1 → pops 1..8 in order, `db_valid` falls after the last pop, OVF stays set until 32'h100 is written to 0x1C.
- Read 0x40 → 32'hDEAD_BEEF with an ack. Build without `CFG_CSR_DB_FIFO_EN`, write 0x18 → `db_valid` stays 0 and a read of 0x1C returns 32'hDEAD_BEEF.
